// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory-access pipeline stage sitting between the EX/MEM and MEM/WB pipeline
// registers. Loads and stores run a request/acknowledge transfer on the data
// bus. The pipeline is held through stallreq_o until the slave acknowledges.
// Store byte lanes and load data are formatted big-endian (lane bit 3 is
// bits[31:24]). This stage also owns the LL/SC link bit.
//
// Handshake: bus_req_o is raised while a transfer is wanted. The transfer
// completes in any cycle where bus_req_o && bus_ack_i. bus_rdata_i is only
// meaningful in that cycle. Address, lanes, write strobe and write data stay
// stable for as long as bus_req_o is high, because EX/MEM holds under
// stallreq_o.
//
// Ports
//   clk, Rst_n                 clock, synchronous active-low reset
//   wd_i/wreg_i/wdata_i        GPR write address / enable / ALU result
//   whilo_i/hi_i/lo_i          HI/LO write (passed through)
//   cp0_reg_*_i                CP0 write (passed through)
//   aluop_i                    operation code
//   mem_addr_i                 effective address
//   reg2_i                     store / SC source data
//   mem_stall_i                MEM/WB is holding this cycle
//   llbit_clr_i                clear link bit (ERET / exception)
//   bus_rdata_i, bus_ack_i     slave read data and transfer acknowledge
//   bus_req_o, bus_we_o        transfer request, write strobe
//   bus_addr_o, bus_sel_o      word address, byte lanes
//   bus_wdata_o                store data replicated onto the lanes
//   stallreq_o                 hold earlier stages
//   misalign_o                 misaligned access detected
//   wd_o ... cp0_reg_data_o    results to MEM/WB
//   llbit_o                    current link bit
//   dbg_state_o                FSM state (0 IDLE, 1 WAIT, 2 DONE)
// -----------------------------------------------------------------------------
module mem_stage (
  input  logic        clk,
  input  logic        Rst_n,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        whilo_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        cp0_reg_we_i,
  input  logic [4:0]  cp0_reg_write_addr_i,
  input  logic [31:0] cp0_reg_data_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic        mem_stall_i,
  input  logic        llbit_clr_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  output logic        stallreq_o,
  output logic        misalign_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        cp0_reg_we_o,
  output logic [4:0]  cp0_reg_write_addr_o,
  output logic [31:0] cp0_reg_data_o,
  output logic        llbit_o,
  output logic [1:0]  dbg_state_o
);

  // Memory operation codes
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [7:0] EXE_LL_OP  = 8'b1111_0000;
  localparam logic [7:0] EXE_SC_OP  = 8'b1111_1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_llbit;
  logic [31:0] r_rdata;

  // Decode
  logic w_is_load;
  logic w_is_store;
  logic w_is_byte;
  logic w_is_half;
  logic w_is_word;
  logic w_is_signed;
  logic w_is_ll;
  logic w_is_sc;

  always_comb begin
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_is_byte   = 1'b0;
    w_is_half   = 1'b0;
    w_is_word   = 1'b0;
    w_is_signed = 1'b0;
    w_is_ll     = 1'b0;
    w_is_sc     = 1'b0;
    case (aluop_i)
      EXE_LB_OP:  begin w_is_load = 1'b1; w_is_byte = 1'b1; w_is_signed = 1'b1; end
      EXE_LBU_OP: begin w_is_load = 1'b1; w_is_byte = 1'b1; end
      EXE_LH_OP:  begin w_is_load = 1'b1; w_is_half = 1'b1; w_is_signed = 1'b1; end
      EXE_LHU_OP: begin w_is_load = 1'b1; w_is_half = 1'b1; end
      EXE_LW_OP:  begin w_is_load = 1'b1; w_is_word = 1'b1; end
      EXE_LL_OP:  begin w_is_load = 1'b1; w_is_word = 1'b1; w_is_ll = 1'b1; end
      EXE_SB_OP:  begin w_is_store = 1'b1; w_is_byte = 1'b1; end
      EXE_SH_OP:  begin w_is_store = 1'b1; w_is_half = 1'b1; end
      EXE_SW_OP:  begin w_is_store = 1'b1; w_is_word = 1'b1; end
      EXE_SC_OP:  begin w_is_store = 1'b1; w_is_word = 1'b1; w_is_sc = 1'b1; end
      default: ;
    endcase
  end

  logic w_misalign;
  logic w_sc_fail;
  logic w_need_bus;
  logic w_req;
  logic w_done_now;
  logic w_in_done;

  assign w_in_done  = (r_state == S_DONE);
  assign w_misalign = (w_is_half & mem_addr_i[0]) | (w_is_word & (mem_addr_i[1:0] != 2'b00));
  // Once an SC has completed, the link bit is already cleared. While the
  // instruction is held in DONE it must still read as a successful SC, so
  // failure is only judged before completion.
  assign w_sc_fail  = w_is_sc & ~r_llbit & ~w_in_done;
  assign w_need_bus = (w_is_load | w_is_store) & ~w_misalign & ~w_sc_fail;
  // DONE suppresses the request so a held instruction is never re-issued.
  assign w_req      = Rst_n & w_need_bus & ~w_in_done;
  assign w_done_now = w_req & bus_ack_i;

  // Byte lanes, big-endian: address 0 is bits[31:24]
  logic [3:0] w_sel;
  always_comb begin
    w_sel = 4'b0000;
    if (w_is_byte) begin
      case (mem_addr_i[1:0])
        2'b00:   w_sel = 4'b1000;
        2'b01:   w_sel = 4'b0100;
        2'b10:   w_sel = 4'b0010;
        default: w_sel = 4'b0001;
      endcase
    end else if (w_is_half) begin
      w_sel = mem_addr_i[1] ? 4'b0011 : 4'b1100;
    end else if (w_is_word) begin
      w_sel = 4'b1111;
    end
  end

  // Store data replicated across every lane the size could select
  logic [31:0] w_store_data;
  always_comb begin
    w_store_data = reg2_i;
    if (w_is_byte)      w_store_data = {4{reg2_i[7:0]}};
    else if (w_is_half) w_store_data = {2{reg2_i[15:0]}};
  end

  // Load formatting. In DONE the bus may be showing anything, so the
  // captured word is used instead.
  logic [31:0] w_rdata_src;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;

  assign w_rdata_src = w_in_done ? r_rdata : bus_rdata_i;

  always_comb begin
    case (mem_addr_i[1:0])
      2'b00:   w_byte = w_rdata_src[31:24];
      2'b01:   w_byte = w_rdata_src[23:16];
      2'b10:   w_byte = w_rdata_src[15:8];
      default: w_byte = w_rdata_src[7:0];
    endcase
    w_half = mem_addr_i[1] ? w_rdata_src[15:0] : w_rdata_src[31:16];

    w_load_val = w_rdata_src;
    if (w_is_byte)      w_load_val = {{24{w_is_signed & w_byte[7]}}, w_byte};
    else if (w_is_half) w_load_val = {{16{w_is_signed & w_half[15]}}, w_half};
  end

  // Result to MEM/WB
  logic [31:0] w_result;
  always_comb begin
    w_result = wdata_i;
    if (w_misalign)     w_result = 32'd0;
    else if (w_is_load) w_result = w_load_val;
    else if (w_is_sc)   w_result = (w_done_now | (w_in_done & ~w_sc_fail)) ? 32'd1 : 32'd0;
  end

  // Outputs; every output reads zero while reset is asserted
  assign bus_req_o   = w_req;
  assign bus_we_o    = w_req & w_is_store;
  assign bus_addr_o  = Rst_n ? {mem_addr_i[31:2], 2'b00} : 32'd0;
  assign bus_sel_o   = w_req ? w_sel : 4'b0000;
  assign bus_wdata_o = (w_req & w_is_store) ? w_store_data : 32'd0;
  assign stallreq_o  = w_req & ~bus_ack_i;
  assign misalign_o  = Rst_n & (w_is_load | w_is_store) & w_misalign;

  assign wd_o        = Rst_n ? wd_i : 5'd0;
  assign wreg_o      = Rst_n & wreg_i & ~((w_is_load | w_is_store) & w_misalign);
  assign wdata_o     = Rst_n ? w_result : 32'd0;

  assign whilo_o              = Rst_n & whilo_i;
  assign hi_o                 = Rst_n ? hi_i : 32'd0;
  assign lo_o                 = Rst_n ? lo_i : 32'd0;
  assign cp0_reg_we_o         = Rst_n & cp0_reg_we_i;
  assign cp0_reg_write_addr_o = Rst_n ? cp0_reg_write_addr_i : 5'd0;
  assign cp0_reg_data_o       = Rst_n ? cp0_reg_data_i : 32'd0;

  assign llbit_o     = Rst_n & r_llbit;
  assign dbg_state_o = Rst_n ? 2'(r_state) : 2'd0;

  // State, link bit and captured read data
  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
      r_llbit <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      if (w_done_now) r_rdata <= bus_rdata_i;

      // Clear has priority over a coincident LL completion
      if (llbit_clr_i)                r_llbit <= 1'b0;
      else if (w_done_now & w_is_ll)  r_llbit <= 1'b1;
      else if (w_done_now & w_is_sc)  r_llbit <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_need_bus) begin
            if (bus_ack_i) r_state <= mem_stall_i ? S_DONE : S_IDLE;
            else           r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!w_need_bus)    r_state <= S_IDLE;
          else if (bus_ack_i) r_state <= mem_stall_i ? S_DONE : S_IDLE;
        end
        S_DONE: begin
          if (!mem_stall_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage: directed bench for mem_stage. Single-cycle behaviour is
// covered by a vector table, and multi-cycle corners by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
  localparam logic [7:0] OP_LL  = 8'b1111_0000;
  localparam logic [7:0] OP_SC  = 8'b1111_1000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // clock / reset
  logic clk;
  logic Rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic        whilo_i;
  logic [31:0] hi_i, lo_i;
  logic        cp0_reg_we_i;
  logic [4:0]  cp0_reg_write_addr_i;
  logic [31:0] cp0_reg_data_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i;
  logic        mem_stall_i, llbit_clr_i;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;

  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic        stallreq_o, misalign_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o, lo_o;
  logic        cp0_reg_we_o;
  logic [4:0]  cp0_reg_write_addr_o;
  logic [31:0] cp0_reg_data_o;
  logic        llbit_o;
  logic [1:0]  dbg_state_o;

  mem_stage dut (
    .clk(clk), .Rst_n(Rst_n),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .whilo_i(whilo_i), .hi_i(hi_i), .lo_i(lo_i),
    .cp0_reg_we_i(cp0_reg_we_i), .cp0_reg_write_addr_i(cp0_reg_write_addr_i),
    .cp0_reg_data_i(cp0_reg_data_i),
    .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .mem_stall_i(mem_stall_i), .llbit_clr_i(llbit_clr_i),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .stallreq_o(stallreq_o), .misalign_o(misalign_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
    .cp0_reg_we_o(cp0_reg_we_o), .cp0_reg_write_addr_o(cp0_reg_write_addr_o),
    .cp0_reg_data_o(cp0_reg_data_o),
    .llbit_o(llbit_o), .dbg_state_o(dbg_state_o)
  );

  // scoreboard counters
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] reg2, input logic [31:0] rdata,
                          input logic ack);
    aluop_i     = op;
    mem_addr_i  = addr;
    reg2_i      = reg2;
    bus_rdata_i = rdata;
    bus_ack_i   = ack;
  endtask

  task automatic drive_idle;
    drive_op(OP_NOP, 32'd0, 32'd0, 32'd0, 1'b0);
    mem_stall_i = 1'b0;
    llbit_clr_i = 1'b0;
  endtask

  // vector table
  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [31:0] rdata;
    logic        ack;
    logic        e_req;
    logic        e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_bwd;
    logic        e_mis;
    logic        e_wreg;
    logic [31:0] e_wdata;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr,
                              input logic [31:0] reg2, input logic [31:0] rdata,
                              input logic ack, input logic e_req, input logic e_we,
                              input logic [3:0] e_sel, input logic [31:0] e_bwd,
                              input logic e_mis, input logic e_wreg,
                              input logic [31:0] e_wdata);
    vec_t v;
    v.op = op; v.addr = addr; v.reg2 = reg2; v.rdata = rdata; v.ack = ack;
    v.e_req = e_req; v.e_we = e_we; v.e_sel = e_sel; v.e_bwd = e_bwd;
    v.e_mis = e_mis; v.e_wreg = e_wreg; v.e_wdata = e_wdata;
    return v;
  endfunction

  vec_t tv[19];

  int n_stall;
  int n_xfer;

  initial begin
    // ALU result presented with every table vector
    tv[0]  = mk(OP_NOP, 32'h1000, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        1'b0, 1'b1, 32'hA5A5A5A5);
    tv[1]  = mk(OP_LB,  32'h1001, 32'h0,        32'h12F35678, 1'b1, 1'b1, 1'b0, 4'h4, 32'h0,        1'b0, 1'b1, 32'hFFFFFFF3);
    tv[2]  = mk(OP_LBU, 32'h1001, 32'h0,        32'h12F35678, 1'b1, 1'b1, 1'b0, 4'h4, 32'h0,        1'b0, 1'b1, 32'h000000F3);
    tv[3]  = mk(OP_LB,  32'h1000, 32'h0,        32'h7FFF0000, 1'b1, 1'b1, 1'b0, 4'h8, 32'h0,        1'b0, 1'b1, 32'h0000007F);
    tv[4]  = mk(OP_LB,  32'h1003, 32'h0,        32'h00000080, 1'b1, 1'b1, 1'b0, 4'h1, 32'h0,        1'b0, 1'b1, 32'hFFFFFF80);
    tv[5]  = mk(OP_LH,  32'h1000, 32'h0,        32'h80011234, 1'b1, 1'b1, 1'b0, 4'hC, 32'h0,        1'b0, 1'b1, 32'hFFFF8001);
    tv[6]  = mk(OP_LHU, 32'h1002, 32'h0,        32'h8001F234, 1'b1, 1'b1, 1'b0, 4'h3, 32'h0,        1'b0, 1'b1, 32'h0000F234);
    tv[7]  = mk(OP_LW,  32'h1004, 32'h0,        32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF);
    tv[8]  = mk(OP_SB,  32'h1002, 32'h000000AB, 32'h0,        1'b1, 1'b1, 1'b1, 4'h2, 32'hABABABAB, 1'b0, 1'b1, 32'hA5A5A5A5);
    tv[9]  = mk(OP_SH,  32'h1002, 32'h0000BEEF, 32'h0,        1'b1, 1'b1, 1'b1, 4'h3, 32'hBEEFBEEF, 1'b0, 1'b1, 32'hA5A5A5A5);
    tv[10] = mk(OP_SW,  32'h1000, 32'h11223344, 32'h0,        1'b1, 1'b1, 1'b1, 4'hF, 32'h11223344, 1'b0, 1'b1, 32'hA5A5A5A5);
    tv[11] = mk(OP_SB,  32'h1003, 32'h12345678, 32'h0,        1'b1, 1'b1, 1'b1, 4'h1, 32'h78787878, 1'b0, 1'b1, 32'hA5A5A5A5);
    tv[12] = mk(OP_LW,  32'h1002, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0);
    tv[13] = mk(OP_LH,  32'h1001, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0);
    tv[14] = mk(OP_SW,  32'h1003, 32'h99999999, 32'h0,        1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0);
    tv[15] = mk(OP_SC,  32'h1000, 32'h00000077, 32'h0,        1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        1'b0, 1'b1, 32'h0);
    tv[16] = mk(OP_LL,  32'h1001, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0);
    tv[17] = mk(OP_LHU, 32'h1000, 32'h0,        32'h8001F234, 1'b1, 1'b1, 1'b0, 4'hC, 32'h0,        1'b0, 1'b1, 32'h00008001);
    tv[18] = mk(OP_SH,  32'h1000, 32'hFFFF1234, 32'h0,        1'b1, 1'b1, 1'b1, 4'hC, 32'h12341234, 1'b0, 1'b1, 32'hA5A5A5A5);

    // reset: every output is held at zero
    Rst_n = 1'b0;
    drive_idle();
    wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hA5A5A5A5;
    whilo_i = 1'b1; hi_i = 32'h01234567; lo_i = 32'h89ABCDEF;
    cp0_reg_we_i = 1'b1; cp0_reg_write_addr_i = 5'd12; cp0_reg_data_i = 32'h00400000;
    drive_op(OP_LW, 32'h100, 32'h0, 32'h55555555, 1'b1);
    #1;
    chk("rst_req",   {31'd0, bus_req_o},  32'd0);
    chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
    chk("rst_wreg",  {31'd0, wreg_o},     32'd0);
    chk("rst_wdata", wdata_o,             32'd0);
    chk("rst_hi",    hi_o,                32'd0);
    chk("rst_cp0",   cp0_reg_data_o,      32'd0);
    repeat (2) next_cycle();
    chk("rst_llbit", {31'd0, llbit_o},    32'd0);
    Rst_n = 1'b1;
    drive_idle();
    #1;
    chk("rst_state", {30'd0, dbg_state_o}, {30'd0, ST_IDLE});
    chk("rst_llbit_after", {31'd0, llbit_o}, 32'd0);

    // pass-through fields
    chk("pt_wd",    {27'd0, wd_o},                 32'd7);
    chk("pt_whilo", {31'd0, whilo_o},              32'd1);
    chk("pt_hi",    hi_o,                          32'h01234567);
    chk("pt_lo",    lo_o,                          32'h89ABCDEF);
    chk("pt_cp0we", {31'd0, cp0_reg_we_o},         32'd1);
    chk("pt_cp0ad", {27'd0, cp0_reg_write_addr_o}, 32'd12);
    chk("pt_cp0d",  cp0_reg_data_o,                32'h00400000);

    // single-cycle vectors (zero-wait slave, no MEM/WB hold)
    for (int i = 0; i < 19; i++) begin
      next_cycle();
      drive_op(tv[i].op, tv[i].addr, tv[i].reg2, tv[i].rdata, tv[i].ack);
      #1;
      chk($sformatf("tv%0d_req", i),   {31'd0, bus_req_o},  {31'd0, tv[i].e_req});
      chk($sformatf("tv%0d_stall", i), {31'd0, stallreq_o}, 32'd0);
      chk($sformatf("tv%0d_mis", i),   {31'd0, misalign_o}, {31'd0, tv[i].e_mis});
      chk($sformatf("tv%0d_wreg", i),  {31'd0, wreg_o},     {31'd0, tv[i].e_wreg});
      chk($sformatf("tv%0d_wdata", i), wdata_o,             tv[i].e_wdata);
      if (tv[i].e_req) begin
        chk($sformatf("tv%0d_sel", i),  {28'd0, bus_sel_o}, {28'd0, tv[i].e_sel});
        chk($sformatf("tv%0d_we", i),   {31'd0, bus_we_o},  {31'd0, tv[i].e_we});
        chk($sformatf("tv%0d_addr", i), bus_addr_o,         {tv[i].addr[31:2], 2'b00});
        if (tv[i].e_we) chk($sformatf("tv%0d_bwd", i), bus_wdata_o, tv[i].e_bwd);
      end
    end
    next_cycle();
    drive_idle();
    #1;
    chk("tbl_llbit", {31'd0, llbit_o}, 32'd0);

    // LB with two wait states, then LBU zero-wait
    n_stall = 0;
    next_cycle();
    drive_op(OP_LB, 32'h1001, 32'h0, 32'h12F35678, 1'b0);
    #1;
    if (stallreq_o) n_stall++;
    chk("lb2_req",  {31'd0, bus_req_o}, 32'd1);
    chk("lb2_sel",  {28'd0, bus_sel_o}, 32'h4);
    next_cycle();
    chk("lb2_wait", {30'd0, dbg_state_o}, {30'd0, ST_WAIT});
    if (stallreq_o) n_stall++;
    next_cycle();
    bus_ack_i = 1'b1;
    #1;
    if (stallreq_o) n_stall++;
    chk("lb2_stall_ack", {31'd0, stallreq_o}, 32'd0);
    chk("lb2_wdata",     wdata_o,             32'hFFFFFFF3);
    chk("lb2_stall_cnt", n_stall,             32'd2);
    next_cycle();
    chk("lb2_idle", {30'd0, dbg_state_o}, {30'd0, ST_IDLE});
    drive_op(OP_LBU, 32'h1001, 32'h0, 32'h12F35678, 1'b1);
    #1;
    chk("lbu_wdata", wdata_o,             32'h000000F3);
    chk("lbu_stall", {31'd0, stallreq_o}, 32'd0);

    // LL then SC, then a second SC that must fail
    next_cycle();
    drive_op(OP_LL, 32'h2000, 32'h0, 32'h0BADF00D, 1'b1);
    #1;
    chk("ll_llbit_pre", {31'd0, llbit_o}, 32'd0);
    chk("ll_wdata",     wdata_o,          32'h0BADF00D);
    next_cycle();
    chk("ll_llbit",     {31'd0, llbit_o}, 32'd1);
    drive_op(OP_SC, 32'h2000, 32'h55AA55AA, 32'h0, 1'b1);
    #1;
    chk("sc_req",   {31'd0, bus_req_o}, 32'd1);
    chk("sc_we",    {31'd0, bus_we_o},  32'd1);
    chk("sc_sel",   {28'd0, bus_sel_o}, 32'hF);
    chk("sc_bwd",   bus_wdata_o,        32'h55AA55AA);
    chk("sc_wdata", wdata_o,            32'd1);
    next_cycle();
    chk("sc_llbit", {31'd0, llbit_o}, 32'd0);
    bus_ack_i = 1'b0;
    #1;
    chk("sc2_req",   {31'd0, bus_req_o},  32'd0);
    chk("sc2_stall", {31'd0, stallreq_o}, 32'd0);
    chk("sc2_wdata", wdata_o,             32'd0);
    chk("sc2_wreg",  {31'd0, wreg_o},     32'd1);

    // llbit_clr_i alone clears a set link bit
    next_cycle();
    drive_op(OP_LL, 32'h2004, 32'h0, 32'h0, 1'b1);
    next_cycle();
    drive_idle();
    llbit_clr_i = 1'b1;
    #1;
    chk("clr_llbit_pre", {31'd0, llbit_o}, 32'd1);
    next_cycle();
    llbit_clr_i = 1'b0;
    chk("clr_llbit", {31'd0, llbit_o}, 32'd0);

    // ack while MEM/WB holds: DONE, single transfer, result from captured data
    n_xfer = 0;
    next_cycle();
    drive_op(OP_LW, 32'h3000, 32'h0, 32'hCAFEF00D, 1'b1);
    mem_stall_i = 1'b1;
    #1;
    if (bus_req_o && bus_ack_i) n_xfer++;
    chk("hold_wdata0", wdata_o, 32'hCAFEF00D);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      bus_rdata_i = 32'h0;
      #1;
      if (bus_req_o && bus_ack_i) n_xfer++;
      chk($sformatf("hold%0d_state", k), {30'd0, dbg_state_o}, {30'd0, ST_DONE});
      chk($sformatf("hold%0d_wdata", k), wdata_o,             32'hCAFEF00D);
      chk($sformatf("hold%0d_stall", k), {31'd0, stallreq_o}, 32'd0);
    end
    chk("hold_xfers", n_xfer, 32'd1);
    next_cycle();
    mem_stall_i = 1'b0;
    bus_ack_i   = 1'b0;
    #1;
    chk("hold_last_wdata", wdata_o, 32'hCAFEF00D);
    next_cycle();
    chk("hold_exit", {30'd0, dbg_state_o}, {30'd0, ST_IDLE});
    drive_idle();

    // reset asserted mid-WAIT abandons the transfer
    next_cycle();
    drive_op(OP_LW, 32'h4000, 32'h0, 32'h0, 1'b0);
    #1;
    chk("rw_stall", {31'd0, stallreq_o}, 32'd1);
    next_cycle();
    chk("rw_wait", {30'd0, dbg_state_o}, {30'd0, ST_WAIT});
    Rst_n = 1'b0;
    bus_ack_i = 1'b1;
    bus_rdata_i = 32'hFFFFFFFF;
    #1;
    chk("rw_req0",   {31'd0, bus_req_o},  32'd0);
    chk("rw_stall0", {31'd0, stallreq_o}, 32'd0);
    chk("rw_wdata0", wdata_o,             32'd0);
    next_cycle();
    Rst_n = 1'b1;
    bus_ack_i = 1'b0;
    #1;
    chk("rw_idle",   {30'd0, dbg_state_o}, {30'd0, ST_IDLE});
    chk("rw_reissue", {31'd0, bus_req_o},  32'd1);
    next_cycle();
    drive_idle();
    next_cycle();
    chk("rw_settle", {30'd0, dbg_state_o}, {30'd0, ST_IDLE});

    // LL completion coincident with llbit_clr_i: clear wins
    drive_op(OP_LL, 32'h5000, 32'h0, 32'h13579BDF, 1'b1);
    llbit_clr_i = 1'b1;
    #1;
    chk("llclr_req", {31'd0, bus_req_o}, 32'd1);
    next_cycle();
    chk("llclr_llbit", {31'd0, llbit_o}, 32'd0);
    drive_idle();

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
